// File: rtl/rr_dist_tree_pkg.sv
// Shared helpers for the round-robin distributor.
// - idx_t    : generic unsigned index type used by the helper functions
// - next_idx : advance an index by one with wrap-around at n
package dist_pkg;

  typedef int unsigned idx_t;

  // Successor of idx in a ring of n entries (n >= 1).
  function automatic idx_t next_idx(idx_t idx, idx_t n);
    return (idx + 1 >= n) ? idx_t'(0) : idx + 1;
  endfunction

endpackage

// File: rtl/rr_dist_tree_if.sv
// Stream bundle for the round-robin distributor.
// - valid_i/ready_o/data_i : single upstream valid/ready stream
// - valid_o/ready_i/data_o : NumOut downstream consumers (data broadcast)
// Modports:
// - slave  : the distributor side
// - master : the environment side (producer plus consumers)
interface rr_dist_tree_if #(
  parameter int NumOut    = 8,
  parameter int DataWidth = 32
);

  logic                              valid_i;
  logic                              ready_o;
  logic [DataWidth-1:0]              data_i;
  logic [NumOut-1:0]                 valid_o;
  logic [NumOut-1:0]                 ready_i;
  logic [NumOut-1:0][DataWidth-1:0]  data_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );

endinterface

// File: rtl/rr_dist_tree_lzc.sv
// Trailing-zero counter: position of the lowest set bit of in_bits.
// - in_bits : input vector
// - cnt     : index of the lowest set bit (0 when empty)
// - empty   : no bit of in_bits is set
module rr_dist_tree_lzc #(
  parameter int Width    = 8,
  parameter int CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_bits,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    cnt   = '0;
    empty = 1'b1;
    // Scan from the top down so the last hit is the lowest set bit.
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_bits[i]) begin
        cnt   = CntWidth'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rr_dist_tree.sv
// Round-robin distributor: steers each upstream beat to one of NumOut consumers.
// - clk_i   : clock, rising edge
// - rst_i   : asynchronous active-high reset
// - flush_i : synchronous clear of the lock; pointer returns to 0
// - rr_i    : external search start (used when ExtPrio=1)
// - idx_o   : output index selected this cycle
// - bus     : upstream stream and per-consumer valid/ready/data
module rr_dist_tree
  import dist_pkg::*;
#(
  parameter int NumOut    = 8,
  parameter int DataWidth = 32,
  parameter bit ExtPrio   = 1'b0,
  parameter bit LockOut   = 1'b1,
  parameter int IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [IdxWidth-1:0] rr_i,
  output logic [IdxWidth-1:0] idx_o,
  rr_dist_tree_if.slave       bus
);

  localparam logic [IdxWidth:0] NumOutW = (IdxWidth + 1)'(NumOut);

  logic [IdxWidth-1:0] rr_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;

  logic [IdxWidth-1:0] start;
  logic [NumOut-1:0]   rot_ready;
  logic [IdxWidth-1:0] cnt;
  logic                none_ready;
  logic [IdxWidth:0]   sum;
  logic [IdxWidth-1:0] idx;
  logic                hs;

  // Search start; an out-of-range external start behaves as 0.
  always_comb begin
    start = rr_q;
    if (ExtPrio) start = (int'(rr_i) < NumOut) ? rr_i : '0;
  end

  // Rotate ready_i right by start so bit j corresponds to output start+j (mod NumOut).
  always_comb begin
    rot_ready = '0;
    for (int j = 0; j < NumOut; j++) begin
      int k;
      k = int'(start) + j;
      if (k >= NumOut) k -= NumOut;
      rot_ready[j] = bus.ready_i[IdxWidth'(k)];
    end
  end

  rr_dist_tree_lzc #(
    .Width    (NumOut),
    .CntWidth (IdxWidth)
  ) u_lzc (
    .in_bits (rot_ready),
    .cnt     (cnt),
    .empty   (none_ready)
  );

  // Map the rotated position back to an absolute index; both operands are
  // below NumOut, so one conditional subtract replaces the modulo.
  always_comb begin
    sum = {1'b0, start} + {1'b0, cnt};
    if (sum >= NumOutW) sum = sum - NumOutW;
    if (lock_q)          idx = lock_idx_q;
    else if (none_ready) idx = start;
    else                 idx = sum[IdxWidth-1:0];
  end

  assign hs = bus.valid_i & bus.ready_i[idx];

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    bus.valid_o = '0;
    for (int k = 0; k < NumOut; k++) begin
      bus.valid_o[k] = bus.valid_i && !rst_i && (idx == IdxWidth'(k));
      bus.data_o[k]  = bus.data_i;
    end
  end

  assign bus.ready_o = hs & ~rst_i;
  assign idx_o       = rst_i ? '0 : idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (flush_i) begin
        rr_q   <= '0;
        lock_q <= 1'b0;
      end else if (hs) begin
        rr_q   <= IdxWidth'(next_idx(idx_t'(idx), idx_t'(NumOut)));
        lock_q <= 1'b0;
      end else if (LockOut && bus.valid_i) begin
        // Pin the pending offer until it is taken.
        lock_q     <= 1'b1;
        lock_idx_q <= idx;
      end
    end
  end

  a_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.valid_o));
  a_lock_valid : assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> bus.valid_i);
  a_idx_range : assert property (@(posedge clk_i) disable iff (rst_i) int'(idx_o) < NumOut);
  a_valid_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.valid_i && !bus.ready_o) |=> bus.valid_i);

endmodule
